// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants and count-width helper
package fifo_pkg;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_W = 2;

    // count must hold 0..2**w inclusive, so it needs one bit more than the pointers
    function automatic int count_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - N x 2**W storage, synchronous write port, asynchronous read port
module fifo_ram #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [N-1:0] w_data,
    input  logic [W-1:0] r_addr,
    output logic [N-1:0] r_data
);

    logic [N-1:0] mem [2**W];

    // Contents are deliberately not reset; the control logic tracks validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - show-ahead FIFO with registered status flags; FIFO_FLAGS_ERR_EN enables sticky ovf/udf
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int W      = DEFAULT_W,
    parameter int AF_THR = 3,
    parameter int AE_THR = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [N-1:0]               w_data,
    input  logic                       rd,
    output logic [N-1:0]               r_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [count_width(W)-1:0]  count,
    input  logic                       err_clr,
    output logic                       ovf,
    output logic                       udf
);

    localparam int CW = count_width(W);
    localparam logic [CW-1:0] DEPTH_C = CW'(2**W);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THR);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THR);

    logic [W-1:0]  w_ptr;
    logic [W-1:0]  r_ptr;
    logic [CW-1:0] count_next;
    logic          wr_acc;
    logic          rd_acc;

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~empty;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Flags are computed from count_next so they land on the same edge as count.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_THR == 0);
        end else begin
            if (wr_acc) w_ptr <= w_ptr + 1'b1;
            if (rd_acc) r_ptr <= r_ptr + 1'b1;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
        end
    end

    fifo_ram #(
        .N (N),
        .W (W)
    ) u_ram (
        .clk    (clk),
        .we     (wr_acc),
        .w_addr (w_ptr),
        .w_data (w_data),
        .r_addr (r_ptr),
        .r_data (r_data)
    );

`ifdef FIFO_FLAGS_ERR_EN
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr && full)  ovf <= 1'b1;
            if (rd && empty) udf <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb/tb_fifo_flags.sv - directed self-checking bench for fifo_flags (N=8, W=2, AF_THR=3, AE_THR=1)
module tb_fifo_flags;

`ifdef FIFO_FLAGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       empty, full, almost_empty, almost_full;
    logic [2:0] count;
    logic       err_clr = 1'b0;
    logic       ovf, udf;

    int passed = 0;
    int total  = 0;

    fifo_flags #(.N(8), .W(2), .AF_THR(3), .AE_THR(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .err_clr      (err_clr),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = 1'b1; rd = 1'b1;
        step();
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
        total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100)
            $display("FAIL reset_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); else passed++;
        total++; if ({ovf, udf} !== 2'b00) $display("FAIL reset_err got %b exp 00", {ovf, udf}); else passed++;
    endtask

    task automatic test_fill();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; w_data = d[i];
            step();
            total++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); else passed++;
            total++; if ({empty, almost_empty, almost_full, full} !== {1'b0, i == 0, i >= 2, i == 3})
                $display("FAIL fill_flags[%0d] got %b exp %b", i, {empty, almost_empty, almost_full, full},
                         {1'b0, i == 0, i >= 2, i == 3}); else passed++;
        end
        w_data = 8'h55;
        step();
        wr = 1'b0;
        total++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL fill_overflow count %0d full %b exp 4 1", count, full); else passed++;
        total++; if (r_data !== 8'h11) $display("FAIL fill_head got %h exp 11", r_data); else passed++;
    endtask

    task automatic test_drain();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            total++; if (r_data !== d[i]) $display("FAIL drain_data[%0d] got %h exp %h", i, r_data, d[i]); else passed++;
            rd = 1'b1;
            step();
            total++; if (count !== 3'(3 - i) || empty !== (i == 3))
                $display("FAIL drain_count[%0d] count %0d empty %b exp %0d %b", i, count, empty, 3 - i, i == 3); else passed++;
        end
        step();
        rd = 1'b0;
        total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL drain_underflow count %0d empty %b exp 0 1", count, empty); else passed++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] d [3] = '{8'hC7, 8'hD8, 8'hE9};
        wr = 1'b1; rd = 1'b1; w_data = 8'hA5;
        step();
        total++; if (count !== 3'd1 || empty !== 1'b0 || r_data !== 8'hA5)
            $display("FAIL simul_empty count %0d empty %b data %h exp 1 0 a5", count, empty, r_data); else passed++;
        rd = 1'b0; w_data = 8'hB6;
        step();
        rd = 1'b1; w_data = 8'hC7;
        step();
        total++; if (count !== 3'd2 || r_data !== 8'hB6 || {almost_empty, almost_full} !== 2'b00)
            $display("FAIL simul_mid count %0d data %h ae_af %b exp 2 b6 00", count, r_data, {almost_empty, almost_full}); else passed++;
        rd = 1'b0; w_data = 8'hD8;
        step();
        w_data = 8'hE9;
        step();
        total++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL simul_fill count %0d full %b exp 4 1", count, full); else passed++;
        rd = 1'b1; w_data = 8'hFF;
        step();
        wr = 1'b0; rd = 1'b0;
        total++; if (count !== 3'd3 || full !== 1'b0 || r_data !== 8'hC7)
            $display("FAIL simul_full count %0d full %b data %h exp 3 0 c7", count, full, r_data); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (r_data !== d[i]) $display("FAIL simul_nooverwrite[%0d] got %h exp %h", i, r_data, d[i]); else passed++;
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        total++; if (empty !== 1'b1) $display("FAIL simul_end empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_wrap();
        int errs = 0;
        for (int k = 0; k < 5; k++) begin
            wr = 1'b1; w_data = 8'(2 * k);
            step();
            w_data = 8'(2 * k + 1);
            step();
            wr = 1'b0;
            if (count !== 3'd2 || full !== 1'b0 || empty !== 1'b0) errs++;
            for (int j = 0; j < 2; j++) begin
                if (r_data !== 8'(2 * k + j)) errs++;
                rd = 1'b1;
                step();
                rd = 1'b0;
            end
            if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) errs++;
        end
        total++; if (errs !== 0) $display("FAIL wrap errors got %0d exp 0", errs); else passed++;
    endtask

    task automatic test_reset_mid();
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = 8'(8'h60 + i);
            step();
        end
        total++; if (count !== 3'd3 || almost_full !== 1'b1) $display("FAIL mid_pre count %0d af %b exp 3 1", count, almost_full); else passed++;
        reset = 1'b1; w_data = 8'h77;
        step();
        reset = 1'b0; wr = 1'b0;
        total++; if (count !== 3'd0 || empty !== 1'b1 || almost_full !== 1'b0)
            $display("FAIL mid_reset count %0d empty %b af %b exp 0 1 0", count, empty, almost_full); else passed++;
        rd = 1'b1;
        step();
        rd = 1'b0;
        total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL mid_read count %0d empty %b exp 0 1", count, empty); else passed++;
    endtask

    task automatic test_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if ({ovf, udf} !== 2'b00) $display("FAIL err_clear0 got %b exp 00", {ovf, udf}); else passed++;
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_data = 8'(i);
            step();
        end
        wr = 1'b0;
        step();
        total++; if (ovf !== ERR_EN || udf !== 1'b0) $display("FAIL err_ovf ovf %b udf %b exp %b 0", ovf, udf, ERR_EN); else passed++;
        rd = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rd = 1'b0;
        step();
        total++; if (ovf !== ERR_EN || udf !== ERR_EN) $display("FAIL err_udf ovf %b udf %b exp %b %b", ovf, udf, ERR_EN, ERR_EN); else passed++;
        err_clr = 1'b1; rd = 1'b1;
        step();
        err_clr = 1'b0; rd = 1'b0;
        total++; if ({ovf, udf} !== 2'b00) $display("FAIL err_clr got %b exp 00", {ovf, udf}); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_errors();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
